// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// The fetch address legality rule lives here so RTL checkers and constants agree.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } if_state_t;

    // A fetch address is legal when word aligned and no higher than the last ROM word.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] max_addr);
        return (addr[1:0] == 2'b00) && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/pc_legal_chk.sv
// Combinational fetch address legality check: word alignment plus upper ROM bound.
module pc_legal_chk
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 256
) (
    input  logic [31:0] i_addr,
    output logic        o_legal
);

    localparam logic [31:0] MAX_ADDR = 32'(IMEM_BYTES - 4);

    assign o_legal = addr_legal(i_addr, MAX_ADDR);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, ROM addressing, IF/ID register with valid/ready
// handshake, branch/jump redirect and sticky fault on illegal fetch addresses.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    localparam logic [31:0] MAX_ADDR    = 32'(IMEM_BYTES - 4);
    localparam logic        RESET_LEGAL = addr_legal(RESET_PC, MAX_ADDR);

    if_state_t          r_state;
    logic [31:0]        r_pc;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [31:0]        r_if_pc;
    logic [31:0]        r_if_pc_plus4;
    logic               r_fault;
    logic [31:0]        r_fetch_count;

    if_state_t          w_state_nxt;
    logic [31:0]        w_pc_nxt;
    logic               w_valid_nxt;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [31:0]        w_if_pc_nxt;
    logic [31:0]        w_if_pc_plus4_nxt;
    logic               w_fault_nxt;
    logic [31:0]        w_count_nxt;

    logic [31:0]        w_pc_plus4;
    logic               w_pc_plus4_legal;
    logic               w_redirect_legal;

    assign w_pc_plus4 = r_pc + 32'd4;

    pc_legal_chk #(.IMEM_BYTES(IMEM_BYTES)) u_seq_chk (
        .i_addr  (w_pc_plus4),
        .o_legal (w_pc_plus4_legal)
    );

    pc_legal_chk #(.IMEM_BYTES(IMEM_BYTES)) u_redir_chk (
        .i_addr  (redirect_pc),
        .o_legal (w_redirect_legal)
    );

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_valid_nxt       = r_if_valid;
        w_instr_nxt       = r_if_instr;
        w_if_pc_nxt       = r_if_pc;
        w_if_pc_plus4_nxt = r_if_pc_plus4;
        w_fault_nxt       = r_fault;
        w_count_nxt       = r_fetch_count;
        case (r_state)
            BOOT: begin
                w_valid_nxt = 1'b0;
                if (RESET_LEGAL) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = 1'b1;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    // Redirect wins even when decode consumes the held word this cycle.
                    w_valid_nxt = 1'b0;
                    if (w_redirect_legal) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = 1'b1;
                    end
                end else if (!r_if_valid || id_ready) begin
                    w_valid_nxt       = 1'b1;
                    w_instr_nxt       = imem_rdata;
                    w_if_pc_nxt       = r_pc;
                    w_if_pc_plus4_nxt = w_pc_plus4;
                    w_count_nxt       = r_fetch_count + 32'd1;
                    if (w_pc_plus4_legal) begin
                        w_pc_nxt = w_pc_plus4;
                    end else begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = 1'b1;
                    end
                end else begin
                    w_valid_nxt = r_if_valid;
                end
            end
            FAULT: begin
                if (id_ready) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = r_if_valid;
                end
            end
            default: begin
                w_state_nxt = FAULT;
                w_fault_nxt = 1'b1;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= 32'h0000_0000;
            r_if_pc_plus4 <= 32'h0000_0000;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_valid    <= w_valid_nxt;
            r_if_instr    <= w_instr_nxt;
            r_if_pc       <= w_if_pc_nxt;
            r_if_pc_plus4 <= w_if_pc_plus4_nxt;
            r_fault       <= w_fault_nxt;
            r_fetch_count <= w_count_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign fault       = r_fault;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a behavioural fetch model over a byte-addressed ROM.
module tb_if_stage;

    localparam int          IMEM_BYTES = 256;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] WORD0      = 32'h2108_000A;
    localparam logic [31:0] WORD1      = 32'h2129_0014;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fault;
    logic [31:0] fetch_count;

    logic [7:0] rom [0:IMEM_BYTES-1];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 = booting, 1 = fetching, 2 = faulted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_count;
    logic        m_valid, m_fault;

    if_stage #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = {rom[{imem_addr[7:2], 2'b11}], rom[{imem_addr[7:2], 2'b10}],
                         rom[{imem_addr[7:2], 2'b01}], rom[{imem_addr[7:2], 2'b00}]};

    function automatic logic legal(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (ua % 4 == 0) && (ua <= IMEM_BYTES - 4);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        int b;
        b = int'(a);
        return {rom[b+3], rom[b+2], rom[b+1], rom[b]};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = RESET_PC; m_valid = 1'b0; m_instr = 32'h0;
        m_ipc = 32'h0; m_ipc4 = 32'h0; m_fault = 1'b0; m_count = 32'h0;
    endtask

    task automatic model_step();
        if (m_mode == 0) begin
            m_valid = 1'b0;
            m_mode  = legal(RESET_PC) ? 1 : 2;
            m_fault = !legal(RESET_PC);
        end else if (m_mode == 1) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                if (legal(redirect_pc)) m_pc = redirect_pc;
                else begin m_mode = 2; m_fault = 1'b1; end
            end else if (!m_valid || id_ready) begin
                m_instr = rom_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_count = m_count + 32'd1;
                if (legal(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
                else begin m_mode = 2; m_fault = 1'b1; end
            end
        end else begin
            if (id_ready) m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_assert();
        n_tests++;
        if ({if_valid, fault, if_instr, if_pc, if_pc_plus4, fetch_count, imem_addr} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, RESET_PC}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b fault=%0b instr=%h pc=%h cnt=%0d addr=%h, expected all zero",
                     if_valid, fault, if_instr, if_pc, fetch_count, imem_addr);
        end
        reset_release();
        cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++; $display("FAIL boot_bubble: if_valid=%0b expected 0", if_valid);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, if_pc, if_instr, if_pc_plus4} !== {1'b1, 32'h0, WORD0, 32'h4}) begin
            n_fail++;
            $display("FAIL first_fetch: valid=%0b pc=%h instr=%h pc4=%h expected 1/0/%h/4",
                     if_valid, if_pc, if_instr, if_pc_plus4, WORD0);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 32'h4, WORD1, 32'd2}) begin
            n_fail++;
            $display("FAIL second_fetch: valid=%0b pc=%h instr=%h cnt=%0d expected 1/4/%h/2",
                     if_valid, if_pc, if_instr, fetch_count, WORD1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        cycle(1'b1, 1'b0, 32'h0);
        held = rom_word(32'h8);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_tests++;
            if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, 32'h8, held, 32'd3}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%0b pc=%h instr=%h cnt=%0d expected 1/8/%h/3",
                         i, if_valid, if_pc, if_instr, fetch_count, held);
            end
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, if_pc, fetch_count} !== {1'b1, 32'hC, 32'd4}) begin
            n_fail++;
            $display("FAIL stall_release: valid=%0b pc=%h cnt=%0d expected 1/c/4", if_valid, if_pc, fetch_count);
        end
    endtask

    task automatic test_redirect();
        int guard = 0;
        while (if_pc !== 32'h24 && guard < 20) begin
            cycle(1'b1, 1'b0, 32'h0);
            guard++;
        end
        n_tests++;
        if (if_pc !== 32'h24) begin
            n_fail++; $display("FAIL reach_0x24: if_pc=%h expected 24", if_pc);
        end
        cycle(1'b1, 1'b1, 32'h0);
        n_tests++;
        if ({if_valid, imem_addr, fault} !== {1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_bubble: valid=%0b addr=%h fault=%0b expected 0/0/0", if_valid, imem_addr, fault);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, WORD0}) begin
            n_fail++;
            $display("FAIL redirect_target: valid=%0b pc=%h instr=%h expected 1/0/%h", if_valid, if_pc, if_instr, WORD0);
        end
    endtask

    task automatic test_bad_redirect(input logic [31:0] bad);
        logic [31:0] addr0, cnt0;
        reset_assert(); reset_release();
        cycle(1'b1, 1'b0, 32'h0); cycle(1'b1, 1'b0, 32'h0); cycle(1'b0, 1'b0, 32'h0);
        addr0 = imem_addr; cnt0 = fetch_count;
        cycle(1'b0, 1'b1, bad);
        n_tests++;
        if ({fault, if_valid, imem_addr} !== {1'b1, 1'b0, addr0}) begin
            n_fail++;
            $display("FAIL bad_redirect_%h: fault=%0b valid=%0b addr=%h expected 1/0/%h",
                     bad, fault, if_valid, imem_addr, addr0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h10);
        n_tests++;
        if ({fault, if_valid, imem_addr, fetch_count} !== {1'b1, 1'b0, addr0, cnt0}) begin
            n_fail++;
            $display("FAIL fault_ignores_redirect_%h: fault=%0b valid=%0b addr=%h cnt=%0d expected 1/0/%h/%0d",
                     bad, fault, if_valid, imem_addr, fetch_count, addr0, cnt0);
        end
    endtask

    task automatic test_seq_end();
        int guard = 0;
        reset_assert(); reset_release();
        while (fault !== 1'b1 && guard < 80) begin
            cycle(1'b1, 1'b0, 32'h0);
            guard++;
        end
        n_tests++;
        if ({fault, if_valid, if_pc, if_instr, if_pc_plus4, fetch_count} !==
            {1'b1, 1'b1, 32'hFC, rom_word(32'hFC), 32'h100, 32'd64}) begin
            n_fail++;
            $display("FAIL seq_end_capture: fault=%0b valid=%0b pc=%h instr=%h pc4=%h cnt=%0d expected 1/1/fc/%h/100/64",
                     fault, if_valid, if_pc, if_instr, if_pc_plus4, fetch_count, rom_word(32'hFC));
        end
        cycle(1'b0, 1'b0, 32'h0); cycle(1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, if_pc} !== {1'b1, 32'hFC}) begin
            n_fail++; $display("FAIL fault_hold: valid=%0b pc=%h expected 1/fc", if_valid, if_pc);
        end
        cycle(1'b1, 1'b0, 32'h0); cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, fetch_count, imem_addr} !== {1'b0, 32'd64, 32'hFC}) begin
            n_fail++;
            $display("FAIL fault_drain: valid=%0b cnt=%0d addr=%h expected 0/64/fc", if_valid, fetch_count, imem_addr);
        end
    endtask

    task automatic test_reset_midstall();
        reset_assert(); reset_release();
        cycle(1'b1, 1'b0, 32'h0); cycle(1'b1, 1'b0, 32'h0); cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        n_tests++;
        if (if_valid !== 1'b1) begin
            n_fail++; $display("FAIL midstall_setup: if_valid=%0b expected 1", if_valid);
        end
        #2;
        reset_assert();
        n_tests++;
        if ({if_valid, if_instr, if_pc, if_pc_plus4, fetch_count, fault, imem_addr} !==
            {1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, RESET_PC}) begin
            n_fail++;
            $display("FAIL async_reset_clear: valid=%0b instr=%h pc=%h cnt=%0d addr=%h expected all zero",
                     if_valid, if_instr, if_pc, fetch_count, imem_addr);
        end
        reset_release();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        n_tests++;
        if ({if_valid, if_pc, if_instr, fetch_count} !== {1'b1, RESET_PC, WORD0, 32'd1}) begin
            n_fail++;
            $display("FAIL restart_after_reset: valid=%0b pc=%h instr=%h cnt=%0d expected 1/0/%h/1",
                     if_valid, if_pc, if_instr, fetch_count, WORD0);
        end
    endtask

    task automatic test_random();
        logic        rdy, rv;
        logic [31:0] rpc;
        reset_assert(); reset_release();
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 9) == 0) rpc = $urandom();
            else rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            cycle(rdy, rv, rpc);
            n_tests++;
            if ({if_valid, if_instr, if_pc, if_pc_plus4, fault, fetch_count, imem_addr} !==
                {m_valid, m_instr, m_ipc, m_ipc4, m_fault, m_count, m_pc}) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%0b i=%h pc=%h pc4=%h f=%0b c=%0d a=%h want v=%0b i=%h pc=%h pc4=%h f=%0b c=%0d a=%h",
                         i, if_valid, if_instr, if_pc, if_pc_plus4, fault, fetch_count, imem_addr,
                         m_valid, m_instr, m_ipc, m_ipc4, m_fault, m_count, m_pc);
            end
            if (m_mode == 2 && !m_valid) begin
                reset_assert(); reset_release();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        for (int b = 0; b < IMEM_BYTES; b++) rom[b] = 8'($urandom());
        {rom[3], rom[2], rom[1], rom[0]} = WORD0;
        {rom[7], rom[6], rom[5], rom[4]} = WORD1;
        model_reset();
        #12;
        test_reset();
        test_stall();
        test_redirect();
        test_bad_redirect(32'h0000_0006);
        test_bad_redirect(32'h0000_0100);
        test_seq_end();
        test_reset_midstall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the MIPS core. Owns the program counter, drives the address of the combinational instruction ROM, captures the returned word into an IF/ID output register with a valid/ready handshake, and applies branch/jump redirects from downstream. Out-of-range or misaligned fetch addresses stop fetch with a sticky fault.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IMEM_BYTES`, default 256: ROM size in bytes; legal fetch addresses are 0 .. IMEM_BYTES-4, word aligned.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: byte address to ROM; always equals the current PC.
- `imem_rdata` in 32: ROM word, combinational from `imem_addr`, little-endian assembled.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: redirect target byte address.
- `id_ready` in 1: decode accepts the IF/ID word this cycle.
- `if_valid` out 1: IF/ID register holds a valid instruction.
- `if_instr` out 32: captured instruction.
- `if_pc` out 32: address of `if_instr`.
- `if_pc_plus4` out 32: `if_pc + 4`, modulo 2^32.
- `fault` out 1: sticky fetch fault.
- `fetch_count` out 32: number of instructions captured, wraps at 2^32.

## Operation
- States: BOOT, RUN, FAULT.
- Reset (async, any time): state=BOOT, PC=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0, `fault`=0, `fetch_count`=0. Mid-operation reset discards the held instruction immediately.
- BOOT: no capture, `if_valid`=0. Next edge goes to RUN, or to FAULT if RESET_PC is illegal.
- RUN, evaluated per edge in priority order:
  - `redirect_valid`=1: `if_valid`<=0, which flushes any held or just-fetched word. If `redirect_pc` is legal, PC<=`redirect_pc`. If illegal, go to FAULT, PC unchanged, `fault`<=1.
  - Else if `if_valid`=0 or `id_ready`=1 (accept slot): capture `if_instr`<=`imem_rdata`, `if_pc`<=PC, `if_pc_plus4`<=PC+4, `if_valid`<=1, `fetch_count`+=1. If PC+4 is legal, PC<=PC+4. Otherwise go to FAULT (the last legal word is still captured) and set `fault`<=1.
  - Else (stall, `if_valid`=1 and `id_ready`=0): everything holds.
- FAULT: PC frozen. Redirects are ignored. The held word drains normally: `if_valid` drops when `id_ready`=1, and no new capture occurs. Only reset exits FAULT.
- Legal address: `addr[1:0]`=0 and `addr` <= IMEM_BYTES-4, unsigned compare on the full 32 bits.
- Redirect and `id_ready` in the same cycle: the current word is consumed by decode, and the redirect still flushes the fetch slot.

## Timing
- Fetch latency: the word at PC appears on `if_instr` with `if_valid`=1 one edge after PC is presented in an accept cycle.
- Throughput: one instruction per cycle while `id_ready`=1.
- First valid instruction: second rising edge after `rst_n` deasserts (BOOT takes one cycle).
- Redirect penalty: one bubble. `if_valid`=0 for exactly one cycle, then the target instruction is valid.
- Stall: `if_instr`, `if_pc` and `if_valid` are stable for as long as `id_ready`=0.
- `fault` rises on the same edge that enters FAULT.

## Structure
- Shared package `mips_pkg`:
  - state enum `if_state_t` {BOOT, RUN, FAULT}
  - `INSTR_W`=32
  - `RESET_PC_DEFAULT`
  - `NOP_INSTR`=32'h0
- One sub-module, `pc_legal_chk`: combinational legality check (alignment plus bound), instantiated twice, once for PC+4 and once for `redirect_pc`.
- PC register, state register and IF/ID register all live in `if_stage`.

## Test plan
- Reset release with ROM word0=0x2108000A and word1=0x21290014, `id_ready`=1: cycle 2 gives `if_pc`=0, `if_instr`=0x2108000A; cycle 3 gives `if_pc`=4, `if_instr`=0x21290014; `fetch_count`=2.
- `id_ready`=0 for 3 cycles while holding PC 8: `if_instr` and `if_pc`=8 stay stable and `fetch_count` does not change; on release, PC 12 follows on the next edge.
- `redirect_valid`=1 with `redirect_pc`=0x0 while at PC 0x24: one cycle with `if_valid`=0, then `if_pc`=0, `if_instr`=0x2108000A.
- `redirect_pc`=0x6 (misaligned) or 0x100 (with IMEM_BYTES=256): `fault`=1 and state FAULT; the held word drains; `if_valid` stays 0 afterwards; later redirects are ignored.
- Sequential fetch reaches 0xFC: word 0xFC is captured, `fault`=1, no further captures.
- Assert `rst_n`=0 mid-stall with `if_valid`=1: all outputs clear asynchronously; after release, fetch restarts at RESET_PC via BOOT.
